seq_detect_ctrl: RTL and testbench

Byte-stream front end and scheduler for the serial sequence detectors in `sequence_detect_10010`. It accepts bytes over a valid/ready handshake and serializes each one MSB-first, one bit per cycle, into a programmable detector. It applies the configured pattern and overlap mode, counts matches per frame, and reports frame completion. It replaces per-pattern hard-wired detector instances, such as one instance for repeat detection and another for non-repeat detection, with one runtime-configured engine.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_shift_detect.sv | 52 +++++
 rtl/seq_detect_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants for the byte-serial sequence detector front end.
// The pattern/repeat defaults match the existing 10010 detector benches.
package seq_detect_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [4:0] DEF_PAT_10010 = 5'b10010;
  localparam logic       DEF_REPEAT_ON = 1'b1;

endpackage

// File: rtl/seq_shift_detect.sv
// Serial pattern detector: bit history, fill counter and comparator.
// o_hit is registered; o_hit_next is the same decision one cycle earlier.
module seq_shift_detect #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_bit_vld,
  input  logic             i_bit_in,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_repeat,
  output logic             o_hit,
  output logic             o_hit_next
);

  localparam int unsigned          FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_hit;

  logic [PAT_W-1:0]  w_hist_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;

  always_comb begin
    w_hist_shift = {r_hist[PAT_W-2:0], i_bit_in};
    w_fill_inc   = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 1'b1;
    w_hit        = i_bit_vld && (w_fill_inc == FILL_MAX) && (w_hist_shift == i_pattern);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= w_hit;
      if (i_bit_vld) begin
        r_hist <= w_hist_shift;
        // Non-overlapping mode: a fresh PAT_W bits are needed after each hit.
        r_fill <= (w_hit && !i_repeat) ? '0 : w_fill_inc;
      end
    end
  end

  assign o_hit      = r_hit;
  assign o_hit_next = w_hit;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-stream front end: accepts bytes, serialises them MSB first into a
// runtime-configured detector, counts matches per frame and flags frame end.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W      = 5,
  parameter logic [PAT_W-1:0] DEF_PAT    = PAT_W'(DEF_PAT_10010),
  parameter logic             DEF_REPEAT = DEF_REPEAT_ON,
  parameter int unsigned      CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_load,
  input  logic [PAT_W-1:0]  i_cfg_pattern,
  input  logic              i_cfg_repeat,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [BYTE_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_match,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int unsigned      IDX_W    = $clog2(BYTE_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_byte;
  logic              r_last;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_repeat;

  logic w_idx_end;
  logic w_accept;
  logic w_first;
  logic w_clr;
  logic w_bit_vld;
  logic w_hit;
  logic w_hit_next;

  always_comb begin
    w_idx_end  = (r_idx == IDX_LAST);
    o_in_ready = 1'b0;
    case (r_state)
      ST_IDLE:  o_in_ready = 1'b1;
      ST_SHIFT: o_in_ready = w_idx_end && !r_last;
      default:  o_in_ready = 1'b0;
    endcase
    w_accept  = i_in_valid && o_in_ready;
    // IDLE with no open frame: the next accept starts a new frame.
    w_first   = (r_state == ST_IDLE) && !r_busy;
    w_clr     = w_accept && w_first;
    w_bit_vld = (r_state == ST_SHIFT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_byte    <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_pattern <= DEF_PAT;
      r_repeat  <= DEF_REPEAT;
    end else begin
      if (w_first && i_cfg_load) begin
        r_pattern <= i_cfg_pattern;
        r_repeat  <= i_cfg_repeat;
      end

      if (w_accept) begin
        r_byte  <= i_in_data;
        r_last  <= i_in_last;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_state <= ST_SHIFT;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            r_byte <= r_byte << 1;
            if (w_idx_end) begin
              // Without a follow-on byte an open frame parks in IDLE, history kept.
              r_state <= r_last ? ST_DONE : ST_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_hit_next && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  seq_shift_detect #(
    .PAT_W (PAT_W)
  ) u_detect (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_bit_vld  (w_bit_vld),
    .i_bit_in   (r_byte[BYTE_W-1]),
    .i_pattern  (r_pattern),
    .i_repeat   (r_repeat),
    .o_hit      (w_hit),
    .o_hit_next (w_hit_next)
  );

  assign o_match      = w_hit;
  assign o_match_cnt  = r_cnt;
  assign o_frame_done = (r_state == ST_DONE);
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a queue-based bit-window model predicts
// every match/frame_done event; a monitor pops and compares as the DUT emits them.
module tb_seq_detect_ctrl;

  localparam int P    = 5;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cfg_load;
  logic [4:0] i_cfg_pattern;
  logic       i_cfg_repeat;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic       i_in_last;
  logic       o_match;
  logic [7:0] o_match_cnt;
  logic       o_frame_done;
  logic       o_busy;

  logic       s_cfg_load;
  logic [1:0] s_cfg_pattern;
  logic       s_cfg_repeat;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_data;
  logic       s_in_last;
  logic       s_match;
  logic [1:0] s_match_cnt;
  logic       s_frame_done;
  logic       s_busy;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_load    (i_cfg_load),
    .i_cfg_pattern (i_cfg_pattern),
    .i_cfg_repeat  (i_cfg_repeat),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_data     (i_in_data),
    .i_in_last     (i_in_last),
    .o_match       (o_match),
    .o_match_cnt   (o_match_cnt),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy)
  );

  seq_detect_ctrl #(
    .PAT_W      (2),
    .DEF_PAT    (2'b11),
    .DEF_REPEAT (1'b1),
    .CNT_W      (2)
  ) dut_s (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_load    (s_cfg_load),
    .i_cfg_pattern (s_cfg_pattern),
    .i_cfg_repeat  (s_cfg_repeat),
    .i_in_valid    (s_in_valid),
    .o_in_ready    (s_in_ready),
    .i_in_data     (s_in_data),
    .i_in_last     (s_in_last),
    .o_match       (s_match),
    .o_match_cnt   (s_match_cnt),
    .o_frame_done  (s_frame_done),
    .o_busy        (s_busy)
  );

  typedef struct {
    int cyc;
    bit m;
    bit d;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  done_seen = 0;

  // Reference model state.
  int  m_pat = 5'b10010;
  bit  m_rep = 1'b1;
  int  m_cnt = 0;
  bit  win[$];
  bit  frame_open = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A match fires when the bits since the last clear (or last non-overlapping
  // match) number at least P and their final P equal the pattern.
  task automatic model_byte(input int t, input logic [7:0] data, input bit last);
    bit  b;
    bit  m;
    int  v;
    ev_t e;
    for (int i = 0; i < 8; i++) begin
      b = data[7-i];
      m = 1'b0;
      win.push_back(b);
      if (win.size() > P) void'(win.pop_front());
      if (win.size() == P) begin
        v = 0;
        for (int k = 0; k < P; k++) v = (v << 1) | int'(win[k]);
        m = (v == m_pat);
      end
      if (m) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!m_rep) win.delete();
      end
      if (m || (last && i == 7)) begin
        e.cyc = t + 2 + i;
        e.m   = m;
        e.d   = last && (i == 7);
        e.cnt = m_cnt;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input bit last, input bit cfg,
                           input logic [4:0] pat, input bit rep, output int t);
    int guard = 0;
    @(negedge clk);
    i_in_valid    = 1'b1;
    i_in_data     = data;
    i_in_last     = last;
    i_cfg_load    = cfg;
    i_cfg_pattern = pat;
    i_cfg_repeat  = rep;
    while (!o_in_ready && guard < 24) begin
      @(negedge clk);
      guard++;
    end
    t = cyc;
    if (!o_in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 24 cycles");
    end else begin
      if (!frame_open) begin
        if (cfg) begin
          m_pat = int'(pat);
          m_rep = rep;
        end
        win.delete();
        m_cnt      = 0;
        frame_open = 1'b1;
      end
      model_byte(t, data, last);
      if (last) frame_open = 1'b0;
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_cfg_load = 1'b0;
  endtask

  // Called right after a last byte: lands on the cycle after DONE.
  task automatic finish_frame(input string name);
    repeat (10) @(negedge clk);
    check({name, "_cnt"}, o_match_cnt, m_cnt);
    check({name, "_busy"}, o_busy, 0);
    check({name, "_ready"}, o_in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (o_frame_done) done_seen++;
    if (o_match || o_frame_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: match=%0d frame_done=%0d at cycle %0d, expected none",
                 o_match, o_frame_done, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_match", o_match, e.m);
        check("ev_done", o_frame_done, e.d);
        check("ev_cnt", o_match_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, d0, k, nb, pulses;
    logic [7:0] data;
    logic [4:0] pat;
    bit rep, cfg;

    rst = 1'b1;
    i_cfg_load = 0; i_cfg_pattern = 0; i_cfg_repeat = 0;
    i_in_valid = 0; i_in_data = 0; i_in_last = 0;
    s_cfg_load = 0; s_cfg_pattern = 0; s_cfg_repeat = 0;
    s_in_valid = 0; s_in_data = 0; s_in_last = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", o_in_ready, 1);
    check("rst_match", o_match, 0);
    check("rst_cnt", o_match_cnt, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_busy", o_busy, 0);

    // Overlapping defaults, single byte 0x92.
    send_byte(8'h92, 1'b1, 1'b0, 5'd0, 1'b0, t);
    repeat (9) @(negedge clk);
    check("ovl_done_ready", o_in_ready, 0);
    check("ovl_done_busy", o_busy, 1);
    check("ovl_done_pulse", o_frame_done, 1);
    @(negedge clk);
    check("ovl_cnt", o_match_cnt, 2);
    check("ovl_busy_clr", o_busy, 0);
    check("ovl_ready_back", o_in_ready, 1);

    // Non-overlapping.
    send_byte(8'h92, 1'b1, 1'b1, 5'b10010, 1'b0, t);
    finish_frame("novl");
    check("novl_cnt_abs", o_match_cnt, 1);

    // Cross-byte, back-to-back.
    send_byte(8'h01, 1'b0, 1'b0, 5'd0, 1'b0, t1);
    send_byte(8'h20, 1'b1, 1'b0, 5'd0, 1'b0, t2);
    check("xbyte_spacing", t2 - t1, 8);
    finish_frame("xbyte");
    check("xbyte_cnt_abs", o_match_cnt, 1);

    // Config ignored while busy.
    send_byte(8'h92, 1'b0, 1'b1, 5'b10010, 1'b1, t);
    repeat (3) @(negedge clk);
    i_cfg_load = 1'b1; i_cfg_pattern = 5'b01101; i_cfg_repeat = 1'b0;
    @(negedge clk);
    i_cfg_load = 1'b0;
    send_byte(8'h6D, 1'b1, 1'b0, 5'd0, 1'b0, t);
    finish_frame("gate");
    check("gate_cnt_abs", o_match_cnt, 2);

    // Reset mid-frame with a non-default config loaded.
    send_byte(8'h00, 1'b0, 1'b1, 5'b11111, 1'b0, t);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    d0  = done_seen;
    @(negedge clk);
    rst = 1'b0;
    m_pat = 5'b10010; m_rep = 1'b1; m_cnt = 0; win.delete(); frame_open = 1'b0;
    check("mrst_ready", o_in_ready, 1);
    check("mrst_match", o_match, 0);
    check("mrst_cnt", o_match_cnt, 0);
    check("mrst_done", o_frame_done, 0);
    check("mrst_busy", o_busy, 0);
    repeat (12) @(negedge clk);
    check("mrst_no_done", done_seen - d0, 0);
    send_byte(8'h92, 1'b1, 1'b0, 5'd0, 1'b0, t);
    finish_frame("mrst_def");
    check("mrst_def_cnt_abs", o_match_cnt, 2);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 2))
          0: pat = 5'b10010;
          1: pat = 5'b10101;
          default: pat = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: data = 8'h92;
          1: data = 8'hAA;
          2: data = 8'h55;
          default: data = 8'($urandom);
        endcase
        rep = 1'($urandom_range(0, 1));
        cfg = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
        send_byte(data, b == nb - 1, cfg, pat, rep, t);
        if (b != nb - 1 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 12)) @(negedge clk);
      end
      if ($urandom_range(0, 1) == 1) finish_frame("rnd");
    end
    repeat (12) @(negedge clk);

    // Saturating counter on the narrow instance.
    @(negedge clk);
    s_in_valid = 1'b1; s_in_data = 8'hFF; s_in_last = 1'b1;
    s_cfg_load = 1'b1; s_cfg_pattern = 2'b11; s_cfg_repeat = 1'b1;
    check("sat_ready", s_in_ready, 1);
    t = cyc;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0; s_cfg_load = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s_match) begin
        pulses++;
        k = (pulses < 3) ? pulses : 3;
        check("sat_pulse_cycle", cyc, t + 2 + pulses);
        check("sat_cnt_step", s_match_cnt, k);
      end
    end
    check("sat_pulses", pulses, 7);
    check("sat_cnt_final", s_match_cnt, 3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
